mmio_uart: RTL and testbench
============================

MMIO_UART -- requirements
Module: mmio_uart

Interface
REQ-001 SHALL have parameter CLOCK_RATE, 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, 115200, reset baud rate; reset divisor = CLOCK_RATE/BAUD_RATE (integer).
REQ-003 SHALL have parameter TX_DEPTH, 16, TX FIFO entries, power of 2, 2..256.
REQ-004 SHALL have parameter RX_DEPTH, 16, RX FIFO entries, power of 2, 2..256.
REQ-005 SHALL have ports: clk  in  1  single clock; rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: sel  in  1  bus access this cycle; write  in  1  1=write 0=read; wmask  in  4  byte enables; addr  in  2  word select (bus addr[3:2]); wdata  in  32  write data; rdata  out  32  read data.
REQ-007 SHALL have ports: uart_rx  in  1  serial input (asynchronous); uart_tx  out  1  serial output; irq  out  1  level interrupt.

Function
REQ-008 SHALL decode addr: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CONTROL; writes take effect only when wmask[0]=1 (DIVISOR: wmask[1:0] as byte enables).
REQ-009 SHALL return rdata registered, exactly one cycle after the sel&~write cycle; rdata holds its value when no read occurs.
REQ-010 SHALL on DATA write push wdata[7:0] into TX FIFO; push while full is dropped and sets sticky STATUS.txovf.
REQ-011 SHALL on DATA read return {23'b0, valid, byte} and pop RX FIFO in the request cycle; empty FIFO returns 0 (valid=0) without pop.
REQ-012 SHALL provide STATUS bits: 0 rx_nonempty, 1 rx_full, 2 tx_empty, 3 tx_full, 4 tx_busy, 5 rxovr, 6 frame_err, 7 parity_err, 8 txovf; bits 5..8 sticky, cleared by STATUS write of 1 to that bit; a set event in the same cycle as a clear wins.
REQ-013 SHALL store DIVISOR as 16 bits; written values below 4 are stored as 4; new value applies from the next frame start in each direction.
REQ-014 SHALL provide CONTROL bits: 0 rx_ie, 1 tx_ie; irq = (rx_ie & rx_nonempty) | (tx_ie & tx_empty & ~tx_busy), registered.
REQ-015 SHALL run TX FSM IDLE->START->DATA(8 bits, LSB first)->[PARITY]->STOP->IDLE, each state DIVISOR cycles; in IDLE a non-empty FIFO pops and starts the next frame without extra idle bit.
REQ-016 SHALL pass uart_rx through a 2-flop synchroniser before use.
REQ-017 SHALL run RX FSM IDLE->START->DATA->[PARITY]->STOP; falling edge in IDLE starts; sample at DIVISOR/2 into START, abort to IDLE if line is high (glitch); subsequent samples every DIVISOR cycles.
REQ-018 SHALL discard the byte and set frame_err when sampled stop bit is 0; RX FSM returns to IDLE after that sample.
REQ-019 SHALL drop a good byte arriving when RX FIFO is full and set rxovr; a pop and push in the same cycle on a full FIFO both succeed.
REQ-020 SHALL treat simultaneous push and pop on an empty FIFO as push only (pop sees empty).

Reset
REQ-021 SHALL on rstn=0 immediately force: uart_tx=1, irq=0, rdata=0, both FSMs IDLE, FIFOs empty, all sticky bits 0, CONTROL=0, DIVISOR=reset divisor; a frame in progress is abandoned.
REQ-022 SHALL initialise the synchroniser flops to 1.

Configuration
REQ-023 SHALL with macro MMIO_UART_PARITY_EN defined insert an even-parity bit after data in TX and check it in RX, setting parity_err and discarding the byte on mismatch.
REQ-024 SHALL without MMIO_UART_PARITY_EN use 8N1 frames, omit the PARITY states, and read parity_err as 0.

Structure
REQ-025 SHALL place register offsets, STATUS/CONTROL bit indices, and TX/RX state enums in package mmio_uart_pkg.
REQ-026 SHALL implement both FIFOs as two instances of sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-027 SHALL cover: DIVISOR write 4, DATA write 0x55 -> uart_tx low 4 cycles, bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high; frame 40 cycles (44 with parity).
REQ-028 SHALL cover: 17 DATA writes with TX_DEPTH=16 while busy -> first byte in shifter, 16 in FIFO, none dropped; 18th write sets txovf.
REQ-029 SHALL cover: loop uart_tx to uart_rx, send 0xA3 -> DATA read returns 0x1A3, STATUS.rx_nonempty then 0; read again returns 0x000.
REQ-030 SHALL cover: inject RX frame with stop bit 0 -> frame_err=1, FIFO empty; STATUS write 0x40 clears it.
REQ-031 SHALL cover: 2-cycle low glitch on uart_rx with DIVISOR=16 -> no byte, no error, FSM back in IDLE.
REQ-032 SHALL cover: rstn asserted mid-TX-frame -> uart_tx=1 same cycle asynchronously, FIFOs empty, DIVISOR = CLOCK_RATE/BAUD_RATE after release.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_pkg
// Description : Shared definitions for the memory-mapped UART: register
//               offsets, STATUS/CONTROL bit positions, TX/RX state encodings
//               and the divisor clamp helper.
//               Optional feature macro: MMIO_UART_PARITY_EN (adds the
//               PARITY states to both state machines).
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Word offsets (bus addr[3:2])
    localparam logic [1:0] c_addr_data    = 2'd0;
    localparam logic [1:0] c_addr_status  = 2'd1;
    localparam logic [1:0] c_addr_divisor = 2'd2;
    localparam logic [1:0] c_addr_control = 2'd3;

    // STATUS bit positions
    localparam int c_st_rx_nonempty = 0;
    localparam int c_st_rx_full     = 1;
    localparam int c_st_tx_empty    = 2;
    localparam int c_st_tx_full     = 3;
    localparam int c_st_tx_busy     = 4;
    localparam int c_st_rxovr       = 5;
    localparam int c_st_frame_err   = 6;
    localparam int c_st_parity_err  = 7;
    localparam int c_st_txovf       = 8;

    // CONTROL bit positions
    localparam int c_ctl_rx_ie = 0;
    localparam int c_ctl_tx_ie = 1;

    // Smallest divisor the bit timers can honour (RX needs DIVISOR/2 >= 2)
    localparam logic [15:0] c_div_min = 16'd4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef MMIO_UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef MMIO_UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < c_div_min) ? c_div_min : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth. Push and pop in the
//               same cycle both succeed when full; a pop on an empty FIFO is
//               ignored even if a push arrives in the same cycle.
// Ports       : clk, rstn (async active-low), push/din, pop/dout (head word,
//               valid while !empty), full, empty, count (entries held).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart
// Description : Memory-mapped UART with TX/RX FIFOs, programmable divisor,
//               sticky error flags and a level interrupt.
//               Optional feature macro: MMIO_UART_PARITY_EN (even parity,
//               8E1 frames); undefined gives 8N1 frames.
// Ports       : clk, rstn (async active-low); bus: sel, write, wmask[3:0],
//               addr[1:0], wdata[31:0], rdata[31:0] (registered);
//               serial: uart_rx (async), uart_tx; irq (registered level).
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart #(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sel,
    input  logic        write,
    input  logic [3:0]  wmask,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    import mmio_uart_pkg::*;

    localparam logic [15:0] c_reset_div = 16'(CLOCK_RATE / BAUD_RATE);
    localparam int          c_tx_cw     = $clog2(TX_DEPTH) + 1;
    localparam int          c_rx_cw     = $clog2(RX_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic w_rd, w_wr0;
    assign w_rd  = sel & ~write;
    assign w_wr0 = sel & write & wmask[0];

    logic [15:0] r_div;
    logic [1:0]  r_ctrl;
    logic        r_rxovr, r_frame_err, r_parity_err, r_txovf;

    // ---------------- FIFOs ----------------
    logic               w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]         w_tx_dout;
    logic [c_tx_cw-1:0] w_tx_count;
    logic               w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]         w_rx_dout;
    logic [c_rx_cw-1:0] w_rx_count;
    logic [7:0]         r_rx_shift;

    assign w_tx_push = w_wr0 & (addr == c_addr_data);
    assign w_rx_pop  = w_rd & (addr == c_addr_data);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(w_tx_push), .din(wdata[7:0]),
        .pop(w_tx_pop), .dout(w_tx_dout), .full(w_tx_full),
        .empty(w_tx_empty), .count(w_tx_count));

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(w_rx_push), .din(r_rx_shift),
        .pop(w_rx_pop), .dout(w_rx_dout), .full(w_rx_full),
        .empty(w_rx_empty), .count(w_rx_count));

    // ---------------- transmitter ----------------
    tx_state_t   r_tx_state;
    logic [15:0] r_tx_div, r_tx_cnt;
    logic [7:0]  r_tx_byte;
    logic [2:0]  r_tx_bit;
    logic        w_tx_tick, w_tx_start, w_tx_busy;

    assign w_tx_tick  = (r_tx_cnt == 16'd0);
    assign w_tx_busy  = (r_tx_state != TX_IDLE);
    // The next frame may start straight out of the last stop-bit cycle
    assign w_tx_start = ~w_tx_empty &
                        ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_tick));
    assign w_tx_pop   = w_tx_start;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state <= TX_IDLE;
            r_tx_div   <= c_reset_div;
            r_tx_cnt   <= 16'd0;
            r_tx_byte  <= 8'd0;
            r_tx_bit   <= 3'd0;
            uart_tx    <= 1'b1;
        end else if (w_tx_start) begin
            r_tx_state <= TX_START;
            r_tx_div   <= r_div;            // divisor frozen for the whole frame
            r_tx_cnt   <= r_div - 16'd1;
            r_tx_byte  <= w_tx_dout;
            r_tx_bit   <= 3'd0;
            uart_tx    <= 1'b0;
        end else if (r_tx_state != TX_IDLE) begin
            if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt - 16'd1;
            end else begin
                r_tx_cnt <= r_tx_div - 16'd1;
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        uart_tx    <= r_tx_byte[0];
                    end
                    TX_DATA: begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (r_tx_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_tx_state <= TX_PARITY;
                            uart_tx    <= ^r_tx_byte;
`else
                            r_tx_state <= TX_STOP;
                            uart_tx    <= 1'b1;
`endif
                        end else begin
                            uart_tx <= r_tx_byte[r_tx_bit + 3'd1];
                        end
                    end
`ifdef MMIO_UART_PARITY_EN
                    TX_PARITY: begin
                        r_tx_state <= TX_STOP;
                        uart_tx    <= 1'b1;
                    end
`endif
                    default: r_tx_state <= TX_IDLE;   // stop done, FIFO empty
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t   r_rx_state;
    logic [1:0]  r_rx_sync;
    logic        r_rx_prev;
    logic [15:0] r_rx_div, r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic        w_rx_in, w_rx_tick, w_rx_stop, w_rx_par_bad;

    assign w_rx_in   = r_rx_sync[1];
    assign w_rx_tick = (r_rx_cnt == 16'd0);
    assign w_rx_stop = (r_rx_state == RX_STOP) & w_rx_tick;
`ifdef MMIO_UART_PARITY_EN
    logic r_rx_par_bad;
    assign w_rx_par_bad = r_rx_par_bad;
`else
    assign w_rx_par_bad = 1'b0;
`endif
    assign w_rx_push = w_rx_stop & w_rx_in & ~w_rx_par_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_div   <= c_reset_div;
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= 8'd0;
            r_rx_bit   <= 3'd0;
`ifdef MMIO_UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
`endif
        end else begin
            r_rx_sync <= {r_rx_sync[0], uart_rx};
            r_rx_prev <= w_rx_in;
            if (r_rx_state == RX_IDLE) begin
                if (r_rx_prev && !w_rx_in) begin
                    r_rx_state <= RX_START;
                    r_rx_div   <= r_div;
                    // first sample lands mid start bit
                    r_rx_cnt   <= {1'b0, r_div[15:1]} - 16'd1;
                end
            end else if (!w_rx_tick) begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end else begin
                r_rx_cnt <= r_rx_div - 16'd1;
                case (r_rx_state)
                    RX_START: begin
                        // line back high at mid start bit: treat as a glitch
                        if (w_rx_in) r_rx_state <= RX_IDLE;
                        else begin
                            r_rx_state <= RX_DATA;
                            r_rx_bit   <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
`ifdef MMIO_UART_PARITY_EN
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        r_rx_par_bad <= w_rx_in ^ (^r_rx_shift);
                        r_rx_state   <= RX_STOP;
                    end
`else
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end
`endif
                    default: r_rx_state <= RX_IDLE;   // stop bit sampled
                endcase
            end
        end
    end

    // ---------------- registers, status, read path ----------------
    logic [8:0]  w_status, w_clr;
    logic [15:0] w_div_new;
    logic [31:0] w_rdata_nx;
    logic        w_div_we;

    assign w_clr     = (w_wr0 && addr == c_addr_status) ? wdata[8:0] : 9'd0;
    assign w_div_we  = sel & write & (addr == c_addr_divisor) & (|wmask[1:0]);
    assign w_div_new = {wmask[1] ? wdata[15:8] : r_div[15:8],
                        wmask[0] ? wdata[7:0]  : r_div[7:0]};

    always_comb begin
        w_status                   = 9'd0;
        w_status[c_st_rx_nonempty] = ~w_rx_empty;
        w_status[c_st_rx_full]     = w_rx_full;
        w_status[c_st_tx_empty]    = w_tx_empty;
        w_status[c_st_tx_full]     = w_tx_full;
        w_status[c_st_tx_busy]     = w_tx_busy;
        w_status[c_st_rxovr]       = r_rxovr;
        w_status[c_st_frame_err]   = r_frame_err;
        w_status[c_st_parity_err]  = r_parity_err;
        w_status[c_st_txovf]       = r_txovf;
    end

    always_comb begin
        w_rdata_nx = 32'd0;
        case (addr)
            c_addr_data:    if (!w_rx_empty) w_rdata_nx = {23'd0, 1'b1, w_rx_dout};
            c_addr_status:  w_rdata_nx = {23'd0, w_status};
            c_addr_divisor: w_rdata_nx = {16'd0, r_div};
            default:        w_rdata_nx = {30'd0, r_ctrl};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div        <= c_reset_div;
            r_ctrl       <= 2'd0;
            r_rxovr      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_txovf      <= 1'b0;
            irq          <= 1'b0;
            rdata        <= 32'd0;
        end else begin
            if (w_div_we) r_div <= clamp_div(w_div_new);
            if (w_wr0 && addr == c_addr_control) r_ctrl <= wdata[1:0];
            // set events take priority over a same-cycle clear
            r_rxovr      <= (w_rx_push & w_rx_full & ~w_rx_pop) |
                            (r_rxovr & ~w_clr[c_st_rxovr]);
            r_frame_err  <= (w_rx_stop & ~w_rx_in) |
                            (r_frame_err & ~w_clr[c_st_frame_err]);
            r_parity_err <= (w_rx_stop & w_rx_in & w_rx_par_bad) |
                            (r_parity_err & ~w_clr[c_st_parity_err]);
            r_txovf      <= (w_tx_push & w_tx_full & ~w_tx_pop) |
                            (r_txovf & ~w_clr[c_st_txovf]);
            irq <= (r_ctrl[c_ctl_rx_ie] & ~w_rx_empty) |
                   (r_ctrl[c_ctl_tx_ie] & w_tx_empty & ~w_tx_busy);
            if (w_rd) rdata <= w_rdata_nx;
        end
    end

    logic w_unused;
    assign w_unused = ^{wdata[31:16], wmask[3:2], w_tx_count, w_rx_count};

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart
// Description : Self-checking bench for mmio_uart. Expected serial waveforms
//               and received bytes come from a frame model (start, 8 data
//               bits LSB first, optional even parity, stop) and byte queues.
//               Honours MMIO_UART_PARITY_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart;

    localparam int CLOCK_RATE = 12_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int RESET_DIV  = CLOCK_RATE / BAUD_RATE;
`ifdef MMIO_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
    logic inj_par_flip = 1'b0;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_DIV = 2'd2, A_CTRL = 2'd3;

    logic        clk = 1'b0, rstn = 1'b0, sel = 1'b0, write = 1'b0;
    logic [3:0]  wmask = 4'd0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        uart_tx, irq, uart_rx_w;
    logic        loop_en = 1'b0, rx_drv = 1'b1;

    int checks = 0;
    int errors = 0;

    assign uart_rx_w = loop_en ? uart_tx : rx_drv;

    mmio_uart #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE),
                .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .write(write), .wmask(wmask),
        .addr(addr), .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx_w),
        .uart_tx(uart_tx), .irq(irq));

    always #5 clk = ~clk;

    // Reference frame: bit idx of the serial frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int idx, input logic stop);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef MMIO_UART_PARITY_EN
        if (idx == 9) return (^b) ^ inj_par_flip;
`endif
        return stop;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        sel = 1'b1; write = 1'b1; addr = a; wdata = d; wmask = m;
        @(negedge clk);
        sel = 1'b0; write = 1'b0; wmask = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; write = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop, input int div);
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx_drv = frame_bit(b, i, stop);
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1 || irq !== 1'b0 || rdata !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: got tx=%b irq=%b rdata=%h required 1 0 0", uart_tx, irq, rdata); end
        rstn = 1'b1;
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL reset_status: got %h required %h", rd, 32'h004); end
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'(RESET_DIV)) begin errors++; $display("FAIL reset_divisor: got %0d required %0d", rd, RESET_DIV); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_control: got %h required 0", rd); end
        bus_read(A_DATA, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_data_empty: got %h required 0", rd); end
    endtask

    task automatic test_tx_frame(input logic [7:0] b, input int div);
        logic [31:0] rd;
        int eff, bad;
        bit seen;
        eff = (div < 4) ? 4 : div;
        bus_write(A_DIV, 32'(div), 4'b0011);
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'(eff)) begin errors++; $display("FAIL div_readback: got %0d required %0d", rd, eff); end
        bus_write(A_DATA, {24'd0, b}, 4'b0001);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (uart_tx === 1'b0) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL tx_start_seen: got no start bit required start within 20 cycles"); end
        bad = 0;
        for (int i = 0; i < FRAME_BITS * eff; i++) begin
            if (uart_tx !== frame_bit(b, i / eff, 1'b1)) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tx_wave byte=%h div=%0d: got %0d wrong samples required 0", b, eff, bad); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004 || uart_tx !== 1'b1) begin
            errors++; $display("FAIL tx_frame_end: got status=%h tx=%b required 004 1", rd, uart_tx); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int bad;
        loop_en = 1'b1;
        bus_write(A_DIV, 32'd4, 4'b0011);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            exp_q.push_back(b);
            sel = 1'b1; write = 1'b1; addr = A_DATA; wmask = 4'b0001; wdata = {24'd0, b};
        end
        @(negedge clk);
        write = 1'b0; addr = A_STAT; wmask = 4'd0;
        @(negedge clk);
        rd = rdata;
        checks++; if (rd !== 32'h018) begin errors++; $display("FAIL tx_fifo_full_17: got status %h required 018", rd); end
        write = 1'b1; addr = A_DATA; wmask = 4'b0001; wdata = 32'h0000_00EE;
        @(negedge clk);
        write = 1'b0; addr = A_STAT; wmask = 4'd0;
        @(negedge clk);
        sel = 1'b0;
        rd = rdata;
        checks++; if (rd !== 32'h118) begin errors++; $display("FAIL txovf_18th: got status %h required 118", rd); end
        for (int k = 0; k < 17 * FRAME_BITS * 4 + 400 && got_q.size() < 17; k++) begin
            bus_read(A_DATA, rd);
            if (rd[8]) got_q.push_back(rd[7:0]);
        end
        checks++; if (got_q.size() != 17) begin errors++; $display("FAIL loop_count: got %0d bytes required 17", got_q.size()); end
        bad = 0;
        for (int i = 0; i < 17 && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL loop_order: got %0d wrong bytes required 0", bad); end
        repeat (20) @(negedge clk);
        bus_write(A_STAT, 32'h100, 4'b0011);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL txovf_clear: got %h required 004", rd); end
        loop_en = 1'b0;
    endtask

    task automatic test_loopback_a3;
        logic [31:0] rd;
        bit seen;
        loop_en = 1'b1;
        bus_write(A_CTRL, 32'd1, 4'b0001);
        bus_write(A_DATA, 32'hA3, 4'b0001);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            bus_read(A_STAT, rd);
            if (rd[0]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL a3_arrival: got no rx_nonempty required within 200 reads"); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b required 1", irq); end
        bus_read(A_DATA, rd);
        checks++; if (rd !== 32'h1A3) begin errors++; $display("FAIL a3_data: got %h required 1a3", rd); end
        bus_read(A_STAT, rd);
        checks++; if (rd[0] !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL a3_drained: got nonempty=%b irq=%b required 0 0", rd[0], irq); end
        bus_read(A_DATA, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL a3_reread: got %h required 0", rd); end
        bus_write(A_CTRL, 32'd0, 4'b0001);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
    endtask

    task automatic test_frame_err;
        logic [31:0] rd;
        logic [7:0] b;
        bus_write(A_DIV, 32'd16, 4'b0011);
        b = 8'($urandom);
        drive_rx_frame(b, 1'b0, 16);
        repeat (4) @(negedge clk);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h044) begin errors++; $display("FAIL frame_err_set: got %h required 044", rd); end
        bus_write(A_STAT, 32'h40, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL frame_err_clear: got %h required 004", rd); end
        b = 8'($urandom);
        drive_rx_frame(b, 1'b1, 16);
        repeat (4) @(negedge clk);
        bus_read(A_DATA, rd);
        checks++; if (rd !== {23'd0, 1'b1, b}) begin errors++; $display("FAIL rx_good_after_err: got %h required %h", rd, {23'd0, 1'b1, b}); end
    endtask

    task automatic test_glitch;
        logic [31:0] rd;
        logic [7:0] b;
        bus_write(A_DIV, 32'd16, 4'b0011);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL glitch_ignored: got %h required 004", rd); end
        b = 8'($urandom);
        drive_rx_frame(b, 1'b1, 16);
        repeat (4) @(negedge clk);
        bus_read(A_DATA, rd);
        checks++; if (rd !== {23'd0, 1'b1, b}) begin errors++; $display("FAIL rx_after_glitch: got %h required %h", rd, {23'd0, 1'b1, b}); end
    endtask

    task automatic test_rx_overflow;
        logic [31:0] rd;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        int bad;
        bus_write(A_DIV, 32'd4, 4'b0011);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < 16) exp_q.push_back(b);
            drive_rx_frame(b, 1'b1, 4);
        end
        repeat (4) @(negedge clk);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h027) begin errors++; $display("FAIL rxovr_set: got %h required 027", rd); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            bus_read(A_DATA, rd);
            if (rd !== {23'd0, 1'b1, exp_q[i]}) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rx_fifo_order: got %0d wrong reads required 0", bad); end
        bus_read(A_DATA, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rx_17th_dropped: got %h required 0", rd); end
        bus_write(A_STAT, 32'h20, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL rxovr_clear: got %h required 004", rd); end
    endtask

    task automatic test_irq_tx;
        bus_write(A_CTRL, 32'd2, 4'b0001);
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq_idle: got %b required 1", irq); end
        bus_write(A_DIV, 32'd16, 4'b0011);
        bus_write(A_DATA, 32'($urandom_range(0, 255)), 4'b0001);
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq_busy: got %b required 0", irq); end
        repeat (FRAME_BITS * 16 + 5) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq_done: got %b required 1", irq); end
        bus_write(A_CTRL, 32'd0, 4'b0001);
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq_disable: got %b required 0", irq); end
    endtask

`ifdef MMIO_UART_PARITY_EN
    task automatic test_parity;
        logic [31:0] rd;
        bus_write(A_DIV, 32'd8, 4'b0011);
        inj_par_flip = 1'b1;
        drive_rx_frame(8'($urandom), 1'b1, 8);
        inj_par_flip = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h084) begin errors++; $display("FAIL parity_err_set: got %h required 084", rd); end
        bus_write(A_STAT, 32'h80, 4'b0001);
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL parity_err_clear: got %h required 004", rd); end
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] rd;
        bit seen, stayed;
        bus_write(A_CTRL, 32'd2, 4'b0001);
        bus_write(A_DIV, 32'd16, 4'b0011);
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'($urandom_range(0, 127)), 4'b0001);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (uart_tx === 1'b0) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_start_seen: got no start bit required one"); end
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1 || irq !== 1'b0 || rdata !== 32'd0) begin
            errors++; $display("FAIL async_reset: got tx=%b irq=%b rdata=%h required 1 0 0", uart_tx, irq, rdata); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        stayed = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (uart_tx !== 1'b1) stayed = 1'b0;
            @(negedge clk);
        end
        checks++; if (!stayed) begin errors++; $display("FAIL reset_no_resume: got tx activity required line idle"); end
        bus_read(A_STAT, rd);
        checks++; if (rd !== 32'h004) begin errors++; $display("FAIL mid_reset_status: got %h required 004", rd); end
        bus_read(A_DIV, rd);
        checks++; if (rd !== 32'(RESET_DIV)) begin errors++; $display("FAIL mid_reset_divisor: got %0d required %0d", rd, RESET_DIV); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL mid_reset_control: got %h required 0", rd); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_frame(8'h55, 4);
        test_tx_frame(8'($urandom), $urandom_range(4, 9));
        test_tx_frame(8'($urandom), 2);
        test_back_to_back();
        test_loopback_a3();
        test_frame_err();
        test_glitch();
        test_rx_overflow();
        test_irq_tx();
`ifdef MMIO_UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
